hs32_aic: RTL and testbench

- Memory-mapped interrupt controller. It is a bus slave hung off one device slot of the HS32 interconnect.
- It consumes that slot's strobe, address, write data and rw, and returns read data and ack.
- It latches up to NI external interrupt lines, masks and prioritises them, and presents one vector to the core.
- The vector is an entry address in an interrupt table (AICT) whose base is software-programmable.

---
 rtl/hs32_aic_if.sv | 12 +
 rtl/hs32_aic.sv | 124 ++++++++++++
 tb/tb_hs32_aic.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hs32_aic_if.sv
// HS32 device-slot bus: strobe/address/data/rw from the interconnect, read data and ack back.
interface hs32_aic_if;
  logic        stb;
  logic        ack;
  logic [31:0] addr;
  logic [31:0] dtw;
  logic        rw;
  logic [31:0] dtr;

  modport master (output stb, output addr, output dtw, output rw, input ack, input dtr);
  modport slave  (input stb, input addr, input dtw, input rw, output ack, output dtr);
endinterface

// File: rtl/hs32_aic.sv
// Interrupt controller: latency ack one cycle after stb, irq outputs one cycle after pending changes.
// Backpressure: none; stb is ignored during the ACK cycle, so a held strobe gives one transfer per two cycles.
module hs32_aic #(
  parameter int NI = 24,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  hs32_aic_if.slave     bus,
  input  logic [NI-1:0] irq_in,
  output logic          irq_valid,
  output logic [31:0]   irq_vec,
  input  logic          irq_ack
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [AW-3:0] OFF_ENABLE = (AW-2)'(0);
  localparam logic [AW-3:0] OFF_PEND   = (AW-2)'(1);
  localparam logic [AW-3:0] OFF_BASE   = (AW-2)'(2);
  localparam logic [AW-3:0] OFF_EDGE   = (AW-2)'(3);
  localparam logic [AW-3:0] OFF_VECTOR = (AW-2)'(4);

  state_t          r_state, w_state_nxt;
  logic [NI-1:0]   r_sync0, r_sync1, r_sync2;
  logic [NI-1:0]   r_enable, r_edge, r_pend;
  logic [31:0]     r_base, r_dtr, r_vec;
  logic            r_valid;
  logic [4:0]      r_idx;

  logic [AW-3:0]   w_off;
  logic            w_wr, w_rd;
  logic [NI-1:0]   w_rise, w_eff, w_act, w_w1c, w_ackclr, w_edge_nxt, w_pend_nxt;
  logic [4:0]      w_idx;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_unused = &{1'b0, bus.addr[31:AW], bus.addr[1:0]};
  assign w_off    = bus.addr[AW-1:2];
  assign w_wr     = (r_state == IDLE) && bus.stb && bus.rw;
  assign w_rd     = (r_state == IDLE) && bus.stb && !bus.rw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.stb) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ack = (r_state == ACK);
  assign bus.dtr = r_dtr;

  assign w_rise = r_sync1 & ~r_sync2;
  assign w_eff  = (r_edge & r_pend) | (~r_edge & r_sync1);
  assign w_act  = w_eff & r_enable;

  always_comb begin
    w_idx = 5'd0;
    for (int i = NI - 1; i >= 0; i--)
      if (w_act[i]) w_idx = 5'(i);
  end

  always_comb begin
    w_ackclr = '0;
    for (int i = 0; i < NI; i++)
      w_ackclr[i] = irq_ack && r_valid && (r_idx == 5'(i));
  end

  assign w_w1c      = (w_wr && w_off == OFF_PEND) ? bus.dtw[NI-1:0] : '0;
  assign w_edge_nxt = (w_wr && w_off == OFF_EDGE) ? bus.dtw[NI-1:0] : r_edge;
  // New edges override clears; dropping a line to level mode discards its stored bit.
  assign w_pend_nxt = ((r_pend & ~w_w1c & ~w_ackclr) | (w_rise & r_edge)) & w_edge_nxt;

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      OFF_ENABLE: w_rdata = 32'(r_enable);
      OFF_PEND:   w_rdata = 32'(w_eff);
      OFF_BASE:   w_rdata = r_base;
      OFF_EDGE:   w_rdata = 32'(r_edge);
      OFF_VECTOR: w_rdata = {r_valid, 26'd0, r_idx};
      default:    w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_enable <= '0;
      r_edge   <= '0;
      r_pend   <= '0;
      r_base   <= 32'd0;
      r_dtr    <= 32'd0;
      r_valid  <= 1'b0;
      r_vec    <= 32'd0;
      r_idx    <= 5'd0;
    end else begin
      r_sync0 <= irq_in;
      r_sync1 <= r_sync0;
      r_sync2 <= r_sync1;
      if (w_wr && w_off == OFF_ENABLE) r_enable <= bus.dtw[NI-1:0];
      if (w_wr && w_off == OFF_BASE)   r_base   <= {bus.dtw[31:2], 2'b00};
      r_edge  <= w_edge_nxt;
      r_pend  <= w_pend_nxt;
      r_valid <= |w_act;
      r_vec   <= r_base + {25'd0, w_idx, 2'b00};
      r_idx   <= w_idx;
      if (w_rd) r_dtr <= w_rdata;
    end
  end

  assign irq_valid = r_valid;
  assign irq_vec   = r_vec;

endmodule

// File: tb/tb_hs32_aic.sv
// Directed bench for hs32_aic: register access, edge/level interrupts, priority, W1C collisions, reset abort.
module tb_hs32_aic;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] irq_in = '0;
  logic        irq_ack = 1'b0;
  logic        irq_valid;
  logic [31:0] irq_vec;
  int          total = 0;
  int          bad = 0;

  hs32_aic_if bus();

  hs32_aic #(.NI(24), .AW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq_in(irq_in),
    .irq_valid(irq_valid), .irq_vec(irq_vec), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // One transfer: returns data and ack seen one cycle after stb, and ack one cycle later.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic ack1, output logic ack2);
    bus.stb = 1'b1; bus.rw = w; bus.addr = a; bus.dtw = d;
    @(negedge clk);
    ack1 = bus.ack; rd = bus.dtr;
    bus.stb = 1'b0; bus.rw = 1'b0;
    @(negedge clk);
    ack2 = bus.ack;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic a1, a2;
    xfer(1'b1, a, d, rd, a1, a2);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd);
    logic a1, a2;
    xfer(1'b0, a, 32'd0, rd, a1, a2);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_irq(input int b);
    irq_in[b] = 1'b1; wait_cyc(2); irq_in[b] = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic a1, a2;
    logic [31:0] offs [5] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    reset = 1'b0; wait_cyc(2);
    total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.ack); end
    total++; if (bus.dtr !== 32'd0) begin bad++; $display("FAIL rst_dtr got=%h exp=0", bus.dtr); end
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", irq_valid); end
    total++; if (irq_vec !== 32'd0) begin bad++; $display("FAIL rst_vec got=%h exp=0", irq_vec); end
    reset = 1'b1; wait_cyc(1);
    foreach (offs[k]) begin
      xfer(1'b0, offs[k], 32'd0, rd, a1, a2);
      total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_read_%h got=%h exp=0", offs[k], rd); end
      total++; if (a1 !== 1'b1 || a2 !== 1'b0) begin bad++; $display("FAIL rst_ack_timing_%h got=%b%b exp=10", offs[k], a1, a2); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    wr(32'h08, 32'h0000_1003); rd_reg(32'h08, rd);
    total++; if (rd !== 32'h0000_1000) begin bad++; $display("FAIL base_rb got=%h exp=00001000", rd); end
    wr(32'h00, 32'hFFFF_FFFF); rd_reg(32'h00, rd);
    total++; if (rd !== 32'h00FF_FFFF) begin bad++; $display("FAIL enable_width got=%h exp=00ffffff", rd); end
    wr(32'h14, 32'h1234_5678); rd_reg(32'h14, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped got=%h exp=0", rd); end
    rd_reg(32'h1C, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL unmapped_1c got=%h exp=0", rd); end
    wr(32'h00, 32'd0);
  endtask

  task automatic test_edge_priority();
    logic [31:0] rd;
    wr(32'h0C, 32'h00FF_FFFF); wr(32'h00, 32'h0000_0021);
    pulse_irq(5); pulse_irq(0); wait_cyc(5);
    total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL edge_valid got=%b exp=1", irq_valid); end
    total++; if (irq_vec !== 32'h0000_1000) begin bad++; $display("FAIL edge_vec0 got=%h exp=00001000", irq_vec); end
    rd_reg(32'h10, rd);
    total++; if (rd !== 32'h8000_0000) begin bad++; $display("FAIL vector_reg got=%h exp=80000000", rd); end
    rd_reg(32'h04, rd);
    total++; if (rd !== 32'h0000_0021) begin bad++; $display("FAIL pend_read got=%h exp=00000021", rd); end
    pulse_ack(); wait_cyc(2);
    total++; if (irq_vec !== 32'h0000_1014 || irq_valid !== 1'b1) begin bad++; $display("FAIL edge_vec5 got=%h/%b exp=00001014/1", irq_vec, irq_valid); end
    pulse_ack(); wait_cyc(2);
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL edge_drain got=%b exp=0", irq_valid); end
  endtask

  task automatic test_level();
    logic [31:0] rd; logic seen_low;
    wr(32'h0C, 32'h00FF_FFF7); wr(32'h00, 32'h0000_0008);
    irq_in[3] = 1'b1; wait_cyc(5);
    total++; if (irq_valid !== 1'b1 || irq_vec !== 32'h0000_100C) begin bad++; $display("FAIL level_vec got=%h/%b exp=0000100c/1", irq_vec, irq_valid); end
    rd_reg(32'h04, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL level_pend got=%h exp=00000008", rd); end
    pulse_ack(); wait_cyc(2);
    total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL level_after_ack got=%b exp=1", irq_valid); end
    irq_in[3] = 1'b0; seen_low = 1'b0;
    for (int i = 0; i < 4 && !seen_low; i++) begin
      @(negedge clk);
      if (irq_valid === 1'b0) seen_low = 1'b1;
    end
    total++; if (!seen_low) begin bad++; $display("FAIL level_release got=%b exp=0 within 4 cycles", irq_valid); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd;
    wr(32'h0C, 32'h00FF_FFFF); wr(32'h00, 32'h0000_0080);
    pulse_irq(7); wait_cyc(5);
    total++; if (irq_vec !== 32'h0000_101C || irq_valid !== 1'b1) begin bad++; $display("FAIL e7_vec got=%h/%b exp=0000101c/1", irq_vec, irq_valid); end
    // Rising edge reaches the pend logic on the same clock that samples the W1C strobe.
    irq_in[7] = 1'b1; wait_cyc(2);
    wr(32'h04, 32'h0000_0080);
    irq_in[7] = 1'b0;
    rd_reg(32'h04, rd);
    total++; if (rd !== 32'h0000_0080) begin bad++; $display("FAIL w1c_collide got=%h exp=00000080", rd); end
    wait_cyc(3);
    wr(32'h04, 32'h0000_0080); rd_reg(32'h04, rd);
    total++; if (rd !== 32'd0 || irq_valid !== 1'b0) begin bad++; $display("FAIL w1c_clear got=%h/%b exp=0/0", rd, irq_valid); end
    pulse_irq(7); wait_cyc(5);
    wr(32'h0C, 32'h00FF_FF7F); rd_reg(32'h04, rd);
    total++; if (rd !== 32'd0 || irq_valid !== 1'b0) begin bad++; $display("FAIL edge_to_level got=%h/%b exp=0/0", rd, irq_valid); end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] rd;
    wr(32'h00, 32'h0000_0005);
    bus.stb = 1'b1; bus.rw = 1'b1; bus.addr = 32'h08; bus.dtw = 32'hABCD_0000;
    @(posedge clk); #2;
    reset = 1'b0; bus.stb = 1'b0; bus.rw = 1'b0;
    @(negedge clk);
    total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", bus.ack); end
    total++; if (irq_valid !== 1'b0 || irq_vec !== 32'd0 || bus.dtr !== 32'd0) begin bad++; $display("FAIL abort_outs got=%b/%h/%h exp=0", irq_valid, irq_vec, bus.dtr); end
    wait_cyc(1); reset = 1'b1; wait_cyc(1);
    rd_reg(32'h00, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_enable got=%h exp=0", rd); end
    rd_reg(32'h08, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_base got=%h exp=0", rd); end
    rd_reg(32'h0C, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_edge got=%h exp=0", rd); end
  endtask

  initial begin
    bus.stb = 1'b0; bus.rw = 1'b0; bus.addr = 32'd0; bus.dtw = 32'd0;
    test_reset();
    test_regs();
    test_edge_priority();
    test_level();
    test_w1c_collision();
    test_reset_midxfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
